// File: rtl/bridge_pkg.sv
// Shared state encoding and line geometry for dcache_mem_bridge.
package bridge_pkg;

    localparam int LINE_BYTES  = 64;
    localparam int OFFSET_BITS = $clog2(LINE_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        CAPTURE,
        RESP
    } state_e;

endpackage

// File: rtl/dcache_mem_bridge_lat_ctr.sv
// 8-bit loadable down-counter that times the memory latency wait.
module mem_lat_ctr (
    input  logic       clk,
    input  logic       rstn,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       dec_i,
    output logic       done_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && (cnt_q != 8'd0))
            cnt_d = cnt_q - 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == 8'd1);

endmodule

// File: rtl/dcache_mem_bridge.sv
// L1 dcache to line-wide RAM bridge: one transaction at a time, programmable latency.
// Optional write acknowledge beat enabled by defining CFG_BRIDGE_WR_ACK_EN.
module dcache_mem_bridge
    import bridge_pkg::*;
#(
    parameter int LINE_WIDTH  = LINE_BYTES * 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [LINE_WIDTH-1:0]   req_wdata,
    input  logic [LINE_WIDTH/8-1:0] req_wstrb,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [LINE_WIDTH-1:0]   resp_rdata,
    output logic                    resp_is_wr,
    output logic [LINE_WIDTH/8-1:0] ram_we,
    output logic [LINE_WIDTH-1:0]   ram_din,
    output logic [ADDR_WIDTH-1:0]   ram_waddr,
    output logic [ADDR_WIDTH-1:0]   ram_raddr,
    input  logic [LINE_WIDTH-1:0]   ram_dout
);

    localparam int LB = LINE_WIDTH / 8;
    localparam int OB = $clog2(LB);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-OB){1'b1}}, {OB{1'b0}}};

`ifdef CFG_BRIDGE_WR_ACK_EN
    localparam state_e WR_NEXT = RESP;
`else
    localparam state_e WR_NEXT = IDLE;
`endif

    state_e                state_q, state_d;
    logic                  lat_we_q, lat_we_d;
    logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
    logic [LINE_WIDTH-1:0] lat_wdata_q, lat_wdata_d;
    logic [LB-1:0]         lat_wstrb_q, lat_wstrb_d;

    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [LINE_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_is_wr_q, resp_is_wr_d;
    logic [LB-1:0]         ram_we_q, ram_we_d;
    logic [LINE_WIDTH-1:0] ram_din_q, ram_din_d;
    logic [ADDR_WIDTH-1:0] ram_waddr_q, ram_waddr_d;
    logic [ADDR_WIDTH-1:0] ram_raddr_q, ram_raddr_d;

    logic accept, cnt_load, cnt_dec, cnt_done;

    mem_lat_ctr u_lat_ctr (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (cnt_load),
        .load_val_i (8'(MEM_LATENCY)),
        .dec_i      (cnt_dec),
        .done_o     (cnt_done)
    );

    always_comb begin
        accept      = (state_q == IDLE) && req_valid && req_ready_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_wstrb_d = lat_wstrb_q;
        if (accept) begin
            lat_we_d    = req_we;
            lat_addr_d  = req_addr & ALIGN_MASK;
            lat_wdata_d = req_wdata;
            lat_wstrb_d = req_wstrb;
        end

        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_load = 1'b1;
                    state_d  = (MEM_LATENCY == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_done) state_d = ACCESS;
            end
            ACCESS:  state_d = lat_we_q ? WR_NEXT : CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state they belong to.
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        ram_we_d     = '0;
        ram_din_d    = ram_din_q;
        ram_waddr_d  = ram_waddr_q;
        ram_raddr_d  = ram_raddr_q;
        if (state_d == ACCESS) begin
            if (lat_we_d) begin
                ram_we_d    = lat_wstrb_d;
                ram_din_d   = lat_wdata_d;
                ram_waddr_d = lat_addr_d;
            end else begin
                ram_raddr_d = lat_addr_d;
            end
        end

        resp_rdata_d = resp_rdata_q;
        if (state_q == CAPTURE) resp_rdata_d = ram_dout;
`ifdef CFG_BRIDGE_WR_ACK_EN
        if ((state_q == ACCESS) && lat_we_q) resp_rdata_d = '0;
        resp_is_wr_d = (state_d == RESP) && lat_we_q;
`else
        resp_is_wr_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            lat_we_q     <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            lat_wstrb_q  <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_is_wr_q <= 1'b0;
            ram_we_q     <= '0;
            ram_din_q    <= '0;
            ram_waddr_q  <= '0;
            ram_raddr_q  <= '0;
        end else begin
            state_q      <= state_d;
            lat_we_q     <= lat_we_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            lat_wstrb_q  <= lat_wstrb_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_is_wr_q <= resp_is_wr_d;
            ram_we_q     <= ram_we_d;
            ram_din_q    <= ram_din_d;
            ram_waddr_q  <= ram_waddr_d;
            ram_raddr_q  <= ram_raddr_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_is_wr = resp_is_wr_q;
    assign ram_we     = ram_we_q;
    assign ram_din    = ram_din_q;
    assign ram_waddr  = ram_waddr_q;
    assign ram_raddr  = ram_raddr_q;

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Directed bench for dcache_mem_bridge: one instance at MEM_LATENCY=4, one at 0, each with a line RAM model.
module tb_dcache_mem_bridge;

    localparam int LW = 512;
    localparam int AW = 16;
    localparam int SB = LW / 8;
`ifdef CFG_BRIDGE_WR_ACK_EN
    localparam int EXP_ACKS = 1;
`else
    localparam int EXP_ACKS = 0;
`endif
    localparam int EXP_ACK_CYC = (EXP_ACKS != 0) ? 6 : 0;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic          req_valid4, req_ready4, req_we4, resp_valid4, resp_ready4, resp_is_wr4;
    logic [AW-1:0] req_addr4, ram_waddr4, ram_raddr4;
    logic [LW-1:0] req_wdata4, resp_rdata4, ram_din4, ram_dout4;
    logic [SB-1:0] req_wstrb4, ram_we4;

    logic          req_valid0, req_ready0, req_we0, resp_valid0, resp_ready0, resp_is_wr0;
    logic [AW-1:0] req_addr0, ram_waddr0, ram_raddr0;
    logic [LW-1:0] req_wdata0, resp_rdata0, ram_din0, ram_dout0;
    logic [SB-1:0] req_wstrb0, ram_we0;

    dcache_mem_bridge #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .MEM_LATENCY(4)) u_dut4 (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_we(req_we4), .req_addr(req_addr4),
        .req_wdata(req_wdata4), .req_wstrb(req_wstrb4),
        .resp_valid(resp_valid4), .resp_ready(resp_ready4), .resp_rdata(resp_rdata4), .resp_is_wr(resp_is_wr4),
        .ram_we(ram_we4), .ram_din(ram_din4), .ram_waddr(ram_waddr4), .ram_raddr(ram_raddr4), .ram_dout(ram_dout4)
    );

    dcache_mem_bridge #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .MEM_LATENCY(0)) u_dut0 (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0), .req_addr(req_addr0),
        .req_wdata(req_wdata0), .req_wstrb(req_wstrb0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_rdata(resp_rdata0), .resp_is_wr(resp_is_wr0),
        .ram_we(ram_we0), .ram_din(ram_din0), .ram_waddr(ram_waddr0), .ram_raddr(ram_raddr0), .ram_dout(ram_dout0)
    );

    // Line RAMs: byte-enabled write, one-cycle synchronous read (old data on collision).
    logic [LW-1:0] mem4 [1024];
    logic [LW-1:0] mem0 [1024];

    always @(posedge clk) begin
        ram_dout4 <= mem4[ram_raddr4[AW-1:6]];
        for (int b = 0; b < SB; b++)
            if (ram_we4[b]) mem4[ram_waddr4[AW-1:6]][b*8 +: 8] = ram_din4[b*8 +: 8];
    end

    always @(posedge clk) begin
        ram_dout0 <= mem0[ram_raddr0[AW-1:6]];
        for (int b = 0; b < SB; b++)
            if (ram_we0[b]) mem0[ram_waddr0[AW-1:6]][b*8 +: 8] = ram_din0[b*8 +: 8];
    end

    int we_cnt4 = 0;
    int we_cnt0 = 0;
    always @(posedge clk) begin
        if (ram_we4 != '0) we_cnt4 <= we_cnt4 + 1;
        if (ram_we0 != '0) we_cnt0 <= we_cnt0 + 1;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic send4(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] d, input logic [SB-1:0] s);
        int n = 0;
        req_we4 = we; req_addr4 = a; req_wdata4 = d; req_wstrb4 = s; req_valid4 = 1'b1;
        while (!req_ready4 && n < 50) begin @(posedge clk); #1; n++; end
        chk("send4_ready", (n < 50), 1);
        @(posedge clk); #1;
        req_valid4 = 1'b0;
    endtask

    task automatic rd4(input logic [AW-1:0] a, output logic [LW-1:0] d);
        int n = 0;
        send4(1'b0, a, '0, '0);
        while (!resp_valid4 && n < 40) begin @(negedge clk); n++; end
        chk("rd4_resp", (n < 40), 1);
        d = resp_rdata4;
        @(negedge clk);
    endtask

    task automatic wr4(input logic [AW-1:0] a, input logic [LW-1:0] d, input logic [SB-1:0] s,
                       output int acks, output logic iswr, output logic [LW-1:0] rdat);
        int n = 0;
        acks = 0; iswr = 1'b0; rdat = '0;
        send4(1'b1, a, d, s);
        while (!req_ready4 && n < 40) begin
            @(negedge clk); n++;
            if (resp_valid4) begin acks++; iswr = resp_is_wr4; rdat = resp_rdata4; end
        end
        chk("wr4_done", (n < 40), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] pat_a5, pat_p, pat_be, rd, wd, d0;
        logic [AW-1:0] wa, ra;
        logic [SB-1:0] ws;
        logic          rr1, iswr;
        int nwe, fwe, nrv, frv, bad, fra, f0, n0, n, base, acks;

        pat_a5 = {64{8'hA5}};
        pat_p  = {{63{8'hA5}}, 8'h3C};
        pat_be = {32{16'hBEEF}};
        for (int i = 0; i < 1024; i++) begin mem4[i] = '0; mem0[i] = '0; end
        mem0[5] = pat_be;

        // Reset held with a pending write request on both instances.
        rstn = 1'b0;
        req_valid4 = 1'b1; req_we4 = 1'b1; req_addr4 = 16'h0040; req_wdata4 = '1; req_wstrb4 = '1;
        req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 16'h0040; req_wdata0 = '1; req_wstrb0 = '1;
        resp_ready4 = 1'b0; resp_ready0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready4, 0);
        chk("rst_resp_valid", resp_valid4, 0);
        chk("rst_resp_rdata", resp_rdata4, 0);
        chk("rst_resp_is_wr", resp_is_wr4, 0);
        chk("rst_ram_we", ram_we4, 0);
        chk("rst_ram_addrs", {ram_waddr4, ram_raddr4}, 0);
        chk("rst_ram_din", ram_din4, 0);
        rstn = 1'b1;
        req_valid4 = 1'b0; req_valid0 = 1'b0;
        @(posedge clk); #1;
        chk("rst_rel_ready4", req_ready4, 1);
        chk("rst_rel_ready0", req_ready0, 1);
        chk("rst_no_ram_write", we_cnt4 + we_cnt0, 0);

        // Full-line write at 0x0040: strobe visible in cycle 5 only.
        resp_ready4 = 1'b1;
        nwe = 0; fwe = 0; nrv = 0; frv = 0; wa = '0; wd = '0; ws = '0;
        send4(1'b1, 16'h0040, pat_a5, '1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ram_we4 != '0) begin
                nwe++;
                if (fwe == 0) fwe = k;
                wa = ram_waddr4; wd = ram_din4; ws = ram_we4;
            end
            if (resp_valid4) begin nrv++; if (frv == 0) frv = k; end
        end
        chk("wr_we_cycle", fwe, 5);
        chk("wr_we_count", nwe, 1);
        chk("wr_waddr", wa, 16'h0040);
        chk("wr_wstrb", ws, {SB{1'b1}});
        chk("wr_din", wd, pat_a5);
        chk("wr_ack_count", nrv, EXP_ACKS);
        chk("wr_ack_cycle", frv, EXP_ACK_CYC);

        // Read of unaligned 0x0047 with resp_ready held low for 10 cycles.
        resp_ready4 = 1'b0;
        frv = 0; bad = 0; ra = '0; rd = '0; rr1 = 1'b1;
        send4(1'b0, 16'h0047, '0, '0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) rr1 = req_ready4;
            if (resp_valid4 && frv == 0) begin frv = k; ra = ram_raddr4; rd = resp_rdata4; end
            if (k >= 7 && (!resp_valid4 || resp_rdata4 !== pat_a5 || req_ready4)) bad++;
        end
        chk("rd_ready_drop", rr1, 0);
        chk("rd_resp_cycle", frv, 7);
        chk("rd_raddr", ra, 16'h0040);
        chk("rd_rdata", rd, pat_a5);
        chk("rd_is_wr", resp_is_wr4, 0);
        chk("rd_hold_stable", bad, 0);
        resp_ready4 = 1'b1;
        @(posedge clk); #1;
        chk("rd_ready_return", req_ready4, 1);
        chk("rd_valid_clear", resp_valid4, 0);

        // Zero-latency instance: read of line 5.
        resp_ready0 = 1'b1;
        req_we0 = 1'b0; req_addr0 = 16'h0145; req_wstrb0 = '0; req_valid0 = 1'b1;
        n = 0;
        while (!req_ready0 && n < 50) begin @(posedge clk); #1; n++; end
        chk("l0_ready", (n < 50), 1);
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        fra = 0; f0 = 0; n0 = 0; d0 = '0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (ram_raddr0 == 16'h0140 && fra == 0) fra = k;
            if (resp_valid0) begin n0++; if (f0 == 0) f0 = k; d0 = resp_rdata0; end
        end
        chk("l0_access_cycle", fra, 1);
        chk("l0_resp_cycle", f0, 3);
        chk("l0_resp_count", n0, 1);
        chk("l0_rdata", d0, pat_be);

        // Partial write of byte 0, then a zero-strobe write that must change nothing.
        wr4(16'h0040, {64{8'h3C}}, 64'h1, acks, iswr, rd);
        rd4(16'h0040, rd);
        chk("part_rdata", rd, pat_p);
        wr4(16'h0047, {64{8'hFF}}, '0, acks, iswr, rd);
        rd4(16'h0040, rd);
        chk("zstrb_rdata", rd, pat_p);

        // Reset during WAIT drops the write.
        base = we_cnt4;
        send4(1'b1, 16'h0080, {64{8'h11}}, '1);
        @(posedge clk); #1;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        nrv = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (resp_valid4) nrv++;
        end
        chk("midrst_no_we", we_cnt4 - base, 0);
        chk("midrst_no_resp", nrv, 0);
        rd4(16'h0080, rd);
        chk("midrst_ram_untouched", rd, 0);

        // New write after reset completes normally.
        wr4(16'h0080, {64{8'h22}}, '1, acks, iswr, wd);
        chk("post_ack_count", acks, EXP_ACKS);
        chk("post_ack_is_wr", iswr, EXP_ACKS);
        chk("post_ack_rdata", wd, 0);
        rd4(16'h0080, rd);
        chk("post_rdata", rd, {64{8'h22}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
